// File: rtl/wb_regfile_if.sv
// Writeback/register-file bus: the MEM/WB read-side fields coming in, and the decode read ports,
// forwarding tap and retire count going out.
interface wb_regfile_if #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int RETIRE_W = 64
);
  localparam int AW = $clog2(NREGS);

  logic                en;
  logic                wbValid;
  logic [XLEN-1:0]     wbPC;
  logic [XLEN-1:0]     wbALUOutput;
  logic [XLEN-1:0]     wbDataOutput;
  logic [AW-1:0]       wbRd;
  logic                wbRegWrite;
  logic [1:0]          wbDataSrc;
  logic [AW-1:0]       rs1Addr;
  logic [AW-1:0]       rs2Addr;
  logic [XLEN-1:0]     rs1Data;
  logic [XLEN-1:0]     rs2Data;
  logic [XLEN-1:0]     fwdData;
  logic [AW-1:0]       fwdRd;
  logic                fwdWrite;
  logic [RETIRE_W-1:0] instret;

  modport master (
    output en, wbValid, wbPC, wbALUOutput, wbDataOutput, wbRd, wbRegWrite, wbDataSrc,
           rs1Addr, rs2Addr,
    input  rs1Data, rs2Data, fwdData, fwdRd, fwdWrite, instret
  );

  modport slave (
    input  en, wbValid, wbPC, wbALUOutput, wbDataOutput, wbRd, wbRegWrite, wbDataSrc,
           rs1Addr, rs2Addr,
    output rs1Data, rs2Data, fwdData, fwdRd, fwdWrite, instret
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result, commits it to the integer register file (x0 fixed at 0),
// serves two bypassed decode read ports and counts retired instructions.
module wb_regfile #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int RETIRE_W = 64
) (
  input logic          clk,
  input logic          rst,
  wb_regfile_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]     regs_q [1:NREGS-1];
  logic [RETIRE_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]     wb_val;
  logic [XLEN-1:0]     rs1_val, rs2_val;
  logic                commit;

  always_comb begin
    case (bus.wbDataSrc)
      2'b01:   wb_val = bus.wbDataOutput;
      2'b10:   wb_val = bus.wbPC + XLEN'(4);
      default: wb_val = bus.wbALUOutput;
    endcase
  end

  // rst is folded in so the reset cycle neither writes nor bypasses
  assign commit = bus.en & bus.wbValid & bus.wbRegWrite & (bus.wbRd != '0) & ~rst;

  always_comb begin
    rs1_val = '0;
    if (bus.rs1Addr != '0) begin
      if (commit && (bus.rs1Addr == bus.wbRd)) rs1_val = wb_val;
      else                                     rs1_val = regs_q[bus.rs1Addr];
    end
  end

  always_comb begin
    rs2_val = '0;
    if (bus.rs2Addr != '0) begin
      if (commit && (bus.rs2Addr == bus.wbRd)) rs2_val = wb_val;
      else                                     rs2_val = regs_q[bus.rs2Addr];
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (bus.en && bus.wbValid) instret_d = instret_q + RETIRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
      instret_q <= '0;
    end else begin
      if (commit) regs_q[bus.wbRd] <= wb_val;
      instret_q <= instret_d;
    end
  end

  assign bus.rs1Data  = rs1_val;
  assign bus.rs2Data  = rs2_val;
  assign bus.fwdData  = wb_val;
  assign bus.fwdWrite = commit;
  assign bus.fwdRd    = commit ? bus.wbRd : '0;
  assign bus.instret  = instret_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, randomized run against a reference model,
// and a narrow-counter build to exercise instret wrap.
module tb_wb_regfile;
  logic clk, rst, rst_s;
  int   n_pass, n_total;

  wb_regfile_if #(.XLEN(32), .NREGS(32), .RETIRE_W(64)) bus ();
  wb_regfile_if #(.XLEN(32), .NREGS(32), .RETIRE_W(4))  bus_s ();

  wb_regfile #(.XLEN(32), .NREGS(32), .RETIRE_W(64)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  wb_regfile #(.XLEN(32), .NREGS(32), .RETIRE_W(4))  u_small (.clk(clk), .rst(rst_s), .bus(bus_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rst, en, v, rw;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] alu, dat, pc;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2, efwd;
    logic        ew;
    logic [4:0]  erd;
    logic [63:0] eret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic en, logic v, logic rw, logic [4:0] rd, logic [1:0] src,
                              logic [31:0] alu, logic [31:0] dat, logic [31:0] pc,
                              logic [4:0] a1, logic [4:0] a2, logic [31:0] e1, logic [31:0] e2,
                              logic [31:0] efwd, logic ew, logic [4:0] erd, logic [63:0] eret);
    vec_t t;
    t.rst = r; t.en = en; t.v = v; t.rw = rw; t.rd = rd; t.src = src;
    t.alu = alu; t.dat = dat; t.pc = pc; t.a1 = a1; t.a2 = a2;
    t.e1 = e1; t.e2 = e2; t.efwd = efwd; t.ew = ew; t.erd = erd; t.eret = eret;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic drive(input logic r, input logic en, input logic v, input logic rw,
                       input logic [4:0] rd, input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] dat, input logic [31:0] pc,
                       input logic [4:0] a1, input logic [4:0] a2);
    rst = r;
    bus.en = en; bus.wbValid = v; bus.wbRegWrite = rw; bus.wbRd = rd; bus.wbDataSrc = src;
    bus.wbALUOutput = alu; bus.wbDataOutput = dat; bus.wbPC = pc;
    bus.rs1Addr = a1; bus.rs2Addr = a2;
  endtask

  // reference model: architectural state plus rule-level writeback semantics
  logic [31:0] m_regs [32];
  logic [63:0] m_ret;

  function automatic logic [31:0] m_sel(logic [1:0] src, logic [31:0] alu, logic [31:0] dat,
                                        logic [31:0] pc);
    if (src == 2'd1) return dat;
    if (src == 2'd2) return pc + 32'd4;
    return alu;
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a, logic cm, logic [4:0] rd, logic [31:0] val);
    if (a == 0) return 32'd0;
    if (cm && a == rd) return val;
    return m_regs[a];
  endfunction

  initial begin
    n_pass = 0; n_total = 0;
    rst_s = 1'b1;
    bus_s.en = 1'b1; bus_s.wbValid = 1'b0; bus_s.wbRegWrite = 1'b0; bus_s.wbRd = '0;
    bus_s.wbDataSrc = '0; bus_s.wbALUOutput = '0; bus_s.wbDataOutput = '0; bus_s.wbPC = '0;
    bus_s.rs1Addr = '0; bus_s.rs2Addr = '0;

    // reset, then every address reads zero
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; rst_s = 1'b0;
    check("reset_instret", bus.instret, 64'd0);
    check("reset_fwdWrite", {63'd0, bus.fwdWrite}, 64'd0);
    check("reset_fwdRd", {59'd0, bus.fwdRd}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rs1Addr = 5'(i); bus.rs2Addr = 5'(31 - i);
      #1;
      check("reset_rs1", {32'd0, bus.rs1Data}, 64'd0);
      check("reset_rs2", {32'd0, bus.rs2Data}, 64'd0);
    end

    //           rst en v rw rd src alu           dat       pc            a1 a2 e1            e2            efwd          ew erd eret
    vecs.push_back(mk(0, 1, 1, 1, 5, 0, 32'hDEADBEEF, 0,        0,            5, 0, 32'hDEADBEEF, 0,            32'hDEADBEEF, 1, 5, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,            0,        0,            5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0,            0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 1, 2, 32'h11,       0,        32'hFFFFFFFC, 1, 5, 0,            32'hDEADBEEF, 0,            1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 2, 1, 32'h22,       32'h80,   0,            2, 1, 32'h80,       0,            32'h80,       1, 2, 2));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 32'h1234,     0,        0,            0, 2, 0,            32'h80,       32'h1234,     0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 1, 7, 0, 32'h55,       0,        0,            7, 7, 0,            0,            32'h55,       0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 1, 7, 0, 32'h55,       0,        0,            7, 0, 0,            0,            32'h55,       0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,            0,        0,            7, 0, 0,            0,            0,            0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 1, 3, 0, 32'hAA,       0,        0,            3, 0, 32'hAA,       0,            32'hAA,       1, 3, 4));
    vecs.push_back(mk(1, 1, 1, 1, 3, 0, 32'hBB,       0,        0,            3, 3, 32'hAA,       32'hAA,       32'hBB,       0, 0, 5));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,            0,        0,            3, 3, 0,            0,            0,            0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 4, 3, 32'h4444,     32'h9,    32'h100,      4, 3, 32'h4444,     0,            32'h4444,     1, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,            0,        0,            4, 3, 32'h4444,     0,            0,            0, 0, 1));

    @(posedge clk); #1;
    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].en, vecs[k].v, vecs[k].rw, vecs[k].rd, vecs[k].src,
            vecs[k].alu, vecs[k].dat, vecs[k].pc, vecs[k].a1, vecs[k].a2);
      @(negedge clk);
      check($sformatf("vec%0d_rs1", k), {32'd0, bus.rs1Data}, {32'd0, vecs[k].e1});
      check($sformatf("vec%0d_rs2", k), {32'd0, bus.rs2Data}, {32'd0, vecs[k].e2});
      check($sformatf("vec%0d_fwdData", k), {32'd0, bus.fwdData}, {32'd0, vecs[k].efwd});
      check($sformatf("vec%0d_fwdWrite", k), {63'd0, bus.fwdWrite}, {63'd0, vecs[k].ew});
      check($sformatf("vec%0d_fwdRd", k), {59'd0, bus.fwdRd}, {59'd0, vecs[k].erd});
      check($sformatf("vec%0d_instret", k), bus.instret, vecs[k].eret);
      @(posedge clk); #1;
    end

    // randomized run against the model, starting from a fresh reset
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ret = '0;
    for (int n = 0; n < 400; n++) begin
      logic r, en, v, rw, cm;
      logic [4:0] rd, a1, a2;
      logic [1:0] src;
      logic [31:0] alu, dat, pc, val;
      r   = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 7) != 0);
      v   = ($urandom_range(0, 5) != 0);
      rw  = ($urandom_range(0, 3) != 0);
      rd  = 5'($urandom_range(0, 31));
      src = 2'($urandom_range(0, 3));
      alu = $urandom; dat = $urandom;
      pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      a1  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      drive(r, en, v, rw, rd, src, alu, dat, pc, a1, a2);
      val = m_sel(src, alu, dat, pc);
      cm  = !r && en && v && rw && rd != 0;
      @(negedge clk);
      check("rand_rs1", {32'd0, bus.rs1Data}, {32'd0, m_read(a1, cm, rd, val)});
      check("rand_rs2", {32'd0, bus.rs2Data}, {32'd0, m_read(a2, cm, rd, val)});
      check("rand_fwdData", {32'd0, bus.fwdData}, {32'd0, val});
      check("rand_fwdWrite", {63'd0, bus.fwdWrite}, {63'd0, cm});
      check("rand_fwdRd", {59'd0, bus.fwdRd}, cm ? {59'd0, rd} : 64'd0);
      check("rand_instret", bus.instret, m_ret);
      @(posedge clk); #1;
      if (r) begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_ret = '0;
      end else begin
        if (cm) m_regs[rd] = val;
        if (en && v) m_ret = m_ret + 64'd1;
      end
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 4-bit counter build: 16 retirements wrap back to 0
    bus_s.wbValid = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("small_instret%0d", k), {60'd0, bus_s.instret}, 64'(k % 16));
      @(posedge clk); #1;
    end
    bus_s.en = 1'b0;
    @(posedge clk); #1;
    check("small_stall", {60'd0, bus_s.instret}, 64'd1);
    bus_s.wbValid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
